// File: rtl/wb_cal_scheduler.sv
// wb_cal_scheduler: decides when the white-balance corrector recalibrates.
//
// A calibration is requested either by software (cal_req_i) or periodically,
// every period_i frames while enable_i is set. A pending request arms the
// scheduler. The next frame start then launches the calibration with a
// one-cycle cal_stb. The calibration finishes when the corrector returns
// cal_done_i. It is aborted, and the sticky timeout_o flag set, if
// TIMEOUT_FRAMES frame starts pass without cal_done_i.
//
// The CSR control values are shadowed on every frame start. The corrector
// therefore only sees changes at frame boundaries.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   frame_start_i            one-cycle pulse per video frame
//   enable_i, period_i       periodic calibration control (period 0 = off)
//   cal_req_i                software calibration request pulse
//   cal_done_i               corrector reports calibration complete
//   tmo_clr_i                clears timeout_o
//   mode_i .. man_lock_i     unshadowed CSR values
//   wb_ctrl_*_o              shadowed controls and cal_stb towards the corrector
//   busy_o                   request pending or calibration in flight
//   timeout_o                sticky abort flag
//   cal_cnt_o                completed calibrations, saturating
module wb_cal_scheduler #(
  parameter int unsigned TIMEOUT_FRAMES = 4,
  parameter int unsigned PERIOD_W       = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                frame_start_i,
  input  logic                enable_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic                cal_req_i,
  input  logic                cal_done_i,
  input  logic                tmo_clr_i,
  input  logic [1:0]          mode_i,
  input  logic [1:0]          man_sel_i,
  input  logic [31:0]         man_coef_i,
  input  logic                man_lock_i,
  output logic [1:0]          wb_ctrl_mode_o,
  output logic                wb_ctrl_cal_stb_o,
  output logic [1:0]          wb_ctrl_man_sel_o,
  output logic [31:0]         wb_ctrl_man_coef_o,
  output logic                wb_ctrl_man_lock_o,
  output logic                busy_o,
  output logic                timeout_o,
  output logic [15:0]         cal_cnt_o
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StArmed = 2'd1;
  localparam logic [1:0] StCalib = 2'd2;

  // tmo_cnt value at which the next frame start aborts the calibration.
  localparam logic [7:0] TmoLast = 8'(TIMEOUT_FRAMES - 1);

  logic [1:0]          state_q, state_d;
  logic                pending_q, pending_d;
  logic [PERIOD_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]          tmo_cnt_q, tmo_cnt_d;
  logic [15:0]         cal_cnt_q, cal_cnt_d;
  logic                timeout_q, timeout_d;
  logic                cal_stb_q, cal_stb_d;
  logic [1:0]          mode_q, mode_d;
  logic [1:0]          man_sel_q, man_sel_d;
  logic [31:0]         man_coef_q, man_coef_d;
  logic                man_lock_q, man_lock_d;

  logic                per_en;
  logic                per_hit;
  logic                req_set;
  logic                take;
  logic                tmo_set;
  logic [PERIOD_W-1:0] period_m1;

  always_comb begin
    period_m1 = period_i - PERIOD_W'(1);
    per_en    = enable_i && (period_i != '0);
    per_hit   = frame_start_i && per_en && (frame_cnt_q >= period_m1);

    frame_cnt_d = frame_cnt_q;
    if (!per_en) begin
      frame_cnt_d = '0;
    end else if (frame_start_i) begin
      frame_cnt_d = per_hit ? '0 : frame_cnt_q + PERIOD_W'(1);
    end

    // Software requests are dropped while calibrating. Periodic ones are kept
    // so that they run after the current calibration finishes.
    req_set   = cal_req_i && (state_q != StCalib);
    take      = (state_q == StIdle) && pending_q;
    pending_d = req_set | per_hit | (pending_q & ~take);

    state_d   = state_q;
    tmo_cnt_d = tmo_cnt_q;
    cal_cnt_d = cal_cnt_q;
    cal_stb_d = 1'b0;
    tmo_set   = 1'b0;

    case (state_q)
      StIdle: begin
        if (pending_q) state_d = StArmed;
      end
      StArmed: begin
        if (frame_start_i) begin
          state_d   = StCalib;
          tmo_cnt_d = '0;
          cal_stb_d = 1'b1;
        end
      end
      StCalib: begin
        if (frame_start_i) tmo_cnt_d = tmo_cnt_q + 8'd1;
        // A completion beats a timeout that lands on the same cycle.
        if (cal_done_i) begin
          state_d = StIdle;
          if (cal_cnt_q != 16'hFFFF) cal_cnt_d = cal_cnt_q + 16'd1;
        end else if (frame_start_i && (tmo_cnt_q == TmoLast)) begin
          state_d = StIdle;
          tmo_set = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    timeout_d = tmo_set | (timeout_q & ~tmo_clr_i);

    mode_d     = mode_q;
    man_sel_d  = man_sel_q;
    man_coef_d = man_coef_q;
    man_lock_d = man_lock_q;
    if (frame_start_i) begin
      mode_d     = mode_i;
      man_sel_d  = man_sel_i;
      man_coef_d = man_coef_i;
      man_lock_d = man_lock_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      pending_q   <= 1'b0;
      frame_cnt_q <= '0;
      tmo_cnt_q   <= '0;
      cal_cnt_q   <= '0;
      timeout_q   <= 1'b0;
      cal_stb_q   <= 1'b0;
      mode_q      <= 2'd2;
      man_sel_q   <= '0;
      man_coef_q  <= '0;
      man_lock_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      frame_cnt_q <= frame_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      cal_cnt_q   <= cal_cnt_d;
      timeout_q   <= timeout_d;
      cal_stb_q   <= cal_stb_d;
      mode_q      <= mode_d;
      man_sel_q   <= man_sel_d;
      man_coef_q  <= man_coef_d;
      man_lock_q  <= man_lock_d;
    end
  end

  assign wb_ctrl_mode_o     = mode_q;
  assign wb_ctrl_cal_stb_o  = cal_stb_q;
  assign wb_ctrl_man_sel_o  = man_sel_q;
  assign wb_ctrl_man_coef_o = man_coef_q;
  assign wb_ctrl_man_lock_o = man_lock_q;
  assign busy_o             = pending_q | (state_q != StIdle);
  assign timeout_o          = timeout_q;
  assign cal_cnt_o          = cal_cnt_q;

endmodule

// File: tb/tb_wb_cal_scheduler.sv
// Directed bench for wb_cal_scheduler. The stimulus covers these cases:
// - manual calibration
// - periodic calibration
// - timeout
// - done/timeout race
// - CSR shadowing
// - reset during a calibration
module tb_wb_cal_scheduler;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        frame_start_i;
  logic        enable_i;
  logic [7:0]  period_i;
  logic        cal_req_i;
  logic        cal_done_i;
  logic        tmo_clr_i;
  logic [1:0]  mode_i;
  logic [1:0]  man_sel_i;
  logic [31:0] man_coef_i;
  logic        man_lock_i;
  logic [1:0]  wb_ctrl_mode_o;
  logic        wb_ctrl_cal_stb_o;
  logic [1:0]  wb_ctrl_man_sel_o;
  logic [31:0] wb_ctrl_man_coef_o;
  logic        wb_ctrl_man_lock_o;
  logic        busy_o;
  logic        timeout_o;
  logic [15:0] cal_cnt_o;

  int n_cmp = 0;
  int n_err = 0;
  int stb_cnt = 0;

  wb_cal_scheduler #(
    .TIMEOUT_FRAMES(4),
    .PERIOD_W      (8)
  ) u_dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .frame_start_i     (frame_start_i),
    .enable_i          (enable_i),
    .period_i          (period_i),
    .cal_req_i         (cal_req_i),
    .cal_done_i        (cal_done_i),
    .tmo_clr_i         (tmo_clr_i),
    .mode_i            (mode_i),
    .man_sel_i         (man_sel_i),
    .man_coef_i        (man_coef_i),
    .man_lock_i        (man_lock_i),
    .wb_ctrl_mode_o    (wb_ctrl_mode_o),
    .wb_ctrl_cal_stb_o (wb_ctrl_cal_stb_o),
    .wb_ctrl_man_sel_o (wb_ctrl_man_sel_o),
    .wb_ctrl_man_coef_o(wb_ctrl_man_coef_o),
    .wb_ctrl_man_lock_o(wb_ctrl_man_lock_o),
    .busy_o            (busy_o),
    .timeout_o         (timeout_o),
    .cal_cnt_o         (cal_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Each strobe cycle contains exactly one falling edge.
  always @(negedge clk_i) if (wb_ctrl_cal_stb_o === 1'b1) stb_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic frame();
    frame_start_i = 1'b1;
    cyc();
    frame_start_i = 1'b0;
  endtask

  // Request, let it arm, then launch with a frame start.
  task automatic start_cal();
    cal_req_i = 1'b1;
    cyc();
    cal_req_i = 1'b0;
    cyc();
    cyc();
    frame();
  endtask

  int stb0;

  initial begin
    rst_i = 1'b1; frame_start_i = 1'b0; enable_i = 1'b0; period_i = 8'd0;
    cal_req_i = 1'b0; cal_done_i = 1'b0; tmo_clr_i = 1'b0;
    mode_i = 2'd1; man_sel_i = 2'd3; man_coef_i = 32'hA5A5_0001; man_lock_i = 1'b1;
    cyc(); cyc();
    check("rst_mode", 32'(wb_ctrl_mode_o), 32'd2);
    check("rst_stb", 32'(wb_ctrl_cal_stb_o), 32'd0);
    check("rst_coef", wb_ctrl_man_coef_o, 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    rst_i = 1'b0;
    cyc();
    check("rst_cnt", 32'(cal_cnt_o), 32'd0);
    check("rst_tmo", 32'(timeout_o), 32'd0);

    // Manual request. The frame start comes 5 cycles after the request.
    cal_req_i = 1'b1;
    cyc();
    cal_req_i = 1'b0;
    check("man_busy_pend", 32'(busy_o), 32'd1);
    cyc();
    cal_done_i = 1'b1;                 // ignored while ARMED
    cyc();
    cal_done_i = 1'b0;
    check("man_done_armed_cnt", 32'(cal_cnt_o), 32'd0);
    cyc(); cyc();
    frame();
    check("man_stb", 32'(wb_ctrl_cal_stb_o), 32'd1);
    check("man_busy", 32'(busy_o), 32'd1);
    check("man_stb_coef", wb_ctrl_man_coef_o, 32'hA5A5_0001);
    check("man_stb_mode", 32'(wb_ctrl_mode_o), 32'd1);
    cyc();
    check("man_stb_1cyc", 32'(wb_ctrl_cal_stb_o), 32'd0);
    cal_done_i = 1'b1;
    cyc();
    cal_done_i = 1'b0;
    check("man_idle", 32'(busy_o), 32'd0);
    check("man_cnt", 32'(cal_cnt_o), 32'd1);

    // Periodic, period 3. Strobes are expected on frames 4, 7 and 10.
    stb0 = stb_cnt;
    enable_i = 1'b1; period_i = 8'd3;
    cyc();
    for (int f = 1; f <= 10; f++) begin
      frame();
      check($sformatf("per_stb_f%0d", f), 32'(wb_ctrl_cal_stb_o),
            (f == 4 || f == 7 || f == 10) ? 32'd1 : 32'd0);
      if (wb_ctrl_cal_stb_o) begin
        cal_done_i = 1'b1;
        cyc();
        cal_done_i = 1'b0;
      end
      cyc(); cyc();
    end
    check("per_stb_total", 32'(stb_cnt - stb0), 32'd3);
    check("per_cnt", 32'(cal_cnt_o), 32'd4);
    check("per_idle", 32'(busy_o), 32'd0);
    enable_i = 1'b0;
    cyc();

    // Timeout. The abort lands together with tmo_clr_i, and the set wins.
    start_cal();
    check("tmo_stb", 32'(wb_ctrl_cal_stb_o), 32'd1);
    for (int f = 1; f <= 3; f++) begin
      cyc();
      frame();
      check($sformatf("tmo_busy_f%0d", f), 32'(busy_o), 32'd1);
    end
    cyc();
    tmo_clr_i = 1'b1;
    frame();
    tmo_clr_i = 1'b0;
    check("tmo_idle", 32'(busy_o), 32'd0);
    check("tmo_flag", 32'(timeout_o), 32'd1);
    check("tmo_cnt_same", 32'(cal_cnt_o), 32'd4);
    cyc();
    check("tmo_sticky", 32'(timeout_o), 32'd1);
    tmo_clr_i = 1'b1;
    cyc();
    tmo_clr_i = 1'b0;
    check("tmo_clr", 32'(timeout_o), 32'd0);

    // cal_done_i arrives on the same cycle as the fourth CALIB frame start.
    start_cal();
    for (int f = 1; f <= 3; f++) begin
      cyc();
      frame();
    end
    cyc();
    cal_done_i = 1'b1;
    frame();
    cal_done_i = 1'b0;
    check("race_cnt", 32'(cal_cnt_o), 32'd5);
    check("race_tmo", 32'(timeout_o), 32'd0);
    check("race_idle", 32'(busy_o), 32'd0);

    // Shadowing: a mid-frame CSR change is not visible until the next frame start.
    man_coef_i = 32'h0100_0080;
    cyc(); cyc(); cyc();
    check("shd_hold", wb_ctrl_man_coef_o, 32'hA5A5_0001);
    frame_start_i = 1'b1;
    check("shd_hold_fs", wb_ctrl_man_coef_o, 32'hA5A5_0001);
    cyc();
    frame_start_i = 1'b0;
    check("shd_update", wb_ctrl_man_coef_o, 32'h0100_0080);

    // Reset in the middle of a calibration.
    start_cal();
    cyc();
    check("rmid_busy_pre", 32'(busy_o), 32'd1);
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    check("rmid_mode", 32'(wb_ctrl_mode_o), 32'd2);
    check("rmid_coef", wb_ctrl_man_coef_o, 32'd0);
    check("rmid_lock", 32'(wb_ctrl_man_lock_o), 32'd0);
    check("rmid_sel", 32'(wb_ctrl_man_sel_o), 32'd0);
    check("rmid_stb", 32'(wb_ctrl_cal_stb_o), 32'd0);
    check("rmid_busy", 32'(busy_o), 32'd0);
    check("rmid_cnt", 32'(cal_cnt_o), 32'd0);
    check("rmid_tmo", 32'(timeout_o), 32'd0);
    cyc();
    frame();
    check("rpost_stb", 32'(wb_ctrl_cal_stb_o), 32'd0);
    check("rpost_busy", 32'(busy_o), 32'd0);
    check("rpost_coef", wb_ctrl_man_coef_o, 32'h0100_0080);
    check("rpost_mode", 32'(wb_ctrl_mode_o), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
